// File: rtl/regfile_mp.sv
// Multi-port integer register file: two combinational read ports, one write port,
// optional hardwired x0, optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
   parameter  int BIT_WIDTH = 32,
   parameter  int NUM_REGS  = 16,
   parameter  int ZERO_REG  = 1,
   parameter  int BYPASS    = 1,
   localparam int ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BIT_WIDTH-1:0] data_in,
   input  logic                 write_en,
   input  logic [ADDR_W-1:0]    write_reg,
   input  logic [ADDR_W-1:0]    read_reg_a,
   input  logic [ADDR_W-1:0]    read_reg_b,
   output logic [BIT_WIDTH-1:0] data_out_a,
   output logic [BIT_WIDTH-1:0] data_out_b,
   input  logic                 busy_set_en,
   input  logic [ADDR_W-1:0]    busy_set_reg,
   output logic                 busy_a,
   output logic                 busy_b,
   output logic                 busy_any
);

   logic [BIT_WIDTH-1:0] reg_val [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_vec;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         localparam bit HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
         logic [BIT_WIDTH-1:0] data_reg;
         logic                 busy_reg;
         logic                 wr_hit;
         logic                 set_hit;

         assign wr_hit  = write_en && (write_reg == ADDR_W'(gi));
         assign set_hit = busy_set_en && (busy_set_reg == ADDR_W'(gi));

         // A set in the same cycle as the clearing write wins: a new writer was issued.
         always_ff @(posedge clk) begin
            if (rst) begin
               data_reg <= '0;
               busy_reg <= 1'b0;
            end else begin
               if (wr_hit && !HARD_ZERO)
                  data_reg <= data_in;
               if (set_hit && !HARD_ZERO)
                  busy_reg <= 1'b1;
               else if (wr_hit)
                  busy_reg <= 1'b0;
            end
         end

         assign reg_val[gi]  = data_reg;
         assign busy_vec[gi] = busy_reg;
      end
   endgenerate

   logic [ADDR_W-1:0]    rd_idx  [2];
   logic [BIT_WIDTH-1:0] rd_data [2];
   logic [1:0]           rd_busy;

   assign rd_idx[0] = read_reg_a;
   assign rd_idx[1] = read_reg_b;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic [BIT_WIDTH-1:0] rd_val;

         // The zero mask is applied last so x0 stays zero even under bypass.
         always_comb begin
            rd_val = reg_val[rd_idx[gi]];
            if ((BYPASS != 0) && write_en && (write_reg == rd_idx[gi]))
               rd_val = data_in;
            if ((ZERO_REG != 0) && (rd_idx[gi] == '0))
               rd_val = '0;
         end

         assign rd_data[gi] = rd_val;
         assign rd_busy[gi] = busy_vec[rd_idx[gi]];
      end
   endgenerate

   assign data_out_a = rd_data[0];
   assign data_out_b = rd_data[1];
   assign busy_a     = rd_busy[0];
   assign busy_b     = rd_busy[1];
   assign busy_any   = |busy_vec;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 16-entry (x0 hardwired, bypass) and a 32-entry
// (plain x0, no bypass) instance share stimulus and are checked against array models.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data_in = '0;
   logic        write_en = 1'b0;
   logic [4:0]  write_reg = '0;
   logic [4:0]  read_reg_a = '0;
   logic [4:0]  read_reg_b = '0;
   logic        busy_set_en = 1'b0;
   logic [4:0]  busy_set_reg = '0;

   logic [31:0] z_dout_a, z_dout_b, n_dout_a, n_dout_b;
   logic        z_busy_a, z_busy_b, z_busy_any, n_busy_a, n_busy_b, n_busy_any;

   always #5 clk = ~clk;

   regfile_mp #(.BIT_WIDTH(32), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(1)) dut_z (
      .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en),
      .write_reg(write_reg[3:0]), .read_reg_a(read_reg_a[3:0]), .read_reg_b(read_reg_b[3:0]),
      .data_out_a(z_dout_a), .data_out_b(z_dout_b),
      .busy_set_en(busy_set_en), .busy_set_reg(busy_set_reg[3:0]),
      .busy_a(z_busy_a), .busy_b(z_busy_b), .busy_any(z_busy_any)
   );

   regfile_mp #(.BIT_WIDTH(32), .NUM_REGS(32), .ZERO_REG(0), .BYPASS(0)) dut_n (
      .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en),
      .write_reg(write_reg), .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
      .data_out_a(n_dout_a), .data_out_b(n_dout_b),
      .busy_set_en(busy_set_en), .busy_set_reg(busy_set_reg),
      .busy_a(n_busy_a), .busy_b(n_busy_b), .busy_any(n_busy_any)
   );

   typedef struct {
      bit          chk;
      int          cyc;
      logic [31:0] z_da, z_db, n_da, n_db;
      logic        z_ba, z_bb, z_any, n_ba, n_bb, n_any;
   } exp_t;

   exp_t exp_q[$];

   // Reference models: register contents and busy sets of each configuration.
   logic [31:0] mz [16];
   logic [31:0] mn [32];
   logic [15:0] bz;
   logic [31:0] bn;
   int cyc_cnt = 0;
   int n_compared = 0;
   int n_mismatched = 0;

   task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
      n_compared++;
      if (act !== req) begin
         n_mismatched++;
         $display("FAIL %s cyc=%0d: got %h required %h", name, cyc, act, req);
      end
   endtask

   task automatic cycle(input bit r, input bit we, input logic [4:0] wr, input logic [31:0] d,
                        input logic [4:0] ra, input logic [4:0] rb, input bit bs, input logic [4:0] bsr);
      exp_t e;
      logic [3:0] za, zb, zw, zs;
      @(posedge clk);
      #1;
      rst = r; write_en = we; write_reg = wr; data_in = d;
      read_reg_a = ra; read_reg_b = rb; busy_set_en = bs; busy_set_reg = bsr;
      za = ra[3:0]; zb = rb[3:0]; zw = wr[3:0]; zs = bsr[3:0];
      e.chk  = !r;
      e.cyc  = cyc_cnt;
      e.z_da = (za == 0) ? 32'h0 : (we && zw == za) ? d : mz[za];
      e.z_db = (zb == 0) ? 32'h0 : (we && zw == zb) ? d : mz[zb];
      e.n_da = mn[ra];
      e.n_db = mn[rb];
      e.z_ba = bz[za]; e.z_bb = bz[zb]; e.z_any = (bz != 0);
      e.n_ba = bn[ra]; e.n_bb = bn[rb]; e.n_any = (bn != 0);
      exp_q.push_back(e);
      $display("cyc %0d rst=%0b we=%0b wr=%0d d=%h ra=%0d rb=%0d bs=%0b bsr=%0d",
               cyc_cnt, r, we, wr, d, ra, rb, bs, bsr);
      cyc_cnt++;
      if (r) begin
         foreach (mz[i]) mz[i] = '0;
         foreach (mn[i]) mn[i] = '0;
         bz = '0;
         bn = '0;
      end else begin
         if (we) begin
            if (zw != 0) mz[zw] = d;
            bz[zw] = 1'b0;
            mn[wr] = d;
            bn[wr] = 1'b0;
         end
         if (bs) begin
            if (zs != 0) bz[zs] = 1'b1;
            bn[bsr] = 1'b1;
         end
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents a response at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               check("z_data_a", e.cyc, z_dout_a, e.z_da);
               check("z_data_b", e.cyc, z_dout_b, e.z_db);
               check("n_data_a", e.cyc, n_dout_a, e.n_da);
               check("n_data_b", e.cyc, n_dout_b, e.n_db);
               check("z_busy_a", e.cyc, {31'h0, z_busy_a}, {31'h0, e.z_ba});
               check("z_busy_b", e.cyc, {31'h0, z_busy_b}, {31'h0, e.z_bb});
               check("z_busy_any", e.cyc, {31'h0, z_busy_any}, {31'h0, e.z_any});
               check("n_busy_a", e.cyc, {31'h0, n_busy_a}, {31'h0, e.n_ba});
               check("n_busy_b", e.cyc, {31'h0, n_busy_b}, {31'h0, e.n_bb});
               check("n_busy_any", e.cyc, {31'h0, n_busy_any}, {31'h0, e.n_any});
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  w, s, a, b;
      logic [31:0] d;
      foreach (mz[i]) mz[i] = '0;
      foreach (mn[i]) mn[i] = '0;
      bz = '0;
      bn = '0;
      repeat (2) @(posedge clk);

      // Reset state on every index of both ports.
      for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
      // Write then read back x5; same-cycle read exercises bypass on one instance only.
      cycle(0, 1, 5, 32'hDEADBEEF, 5, 5, 0, 0);
      cycle(0, 0, 0, 0, 5, 5, 0, 0);
      // x0 writes and busy_set on x0.
      cycle(0, 1, 0, 32'h12345678, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 32'h0, 0, 0, 0, 0);
      // Bypass versus old value on x3.
      cycle(0, 1, 3, 32'h1, 3, 3, 0, 0);
      cycle(0, 1, 3, 32'hA5A5A5A5, 3, 3, 0, 0);
      cycle(0, 0, 0, 0, 3, 3, 0, 0);
      // Scoreboard: set, clear, then simultaneous set and write.
      cycle(0, 0, 0, 0, 7, 7, 1, 7);
      cycle(0, 0, 0, 0, 7, 2, 0, 0);
      cycle(0, 1, 7, 32'h77, 7, 7, 0, 0);
      cycle(0, 0, 0, 0, 7, 7, 0, 0);
      cycle(0, 1, 7, 32'h777, 7, 7, 1, 7);
      cycle(0, 1, 4, 32'h44, 7, 4, 1, 6);
      cycle(0, 0, 0, 0, 7, 6, 0, 0);
      // Reset coincident with a write and busy_set of x9.
      cycle(0, 0, 0, 0, 9, 9, 1, 9);
      cycle(1, 1, 9, 32'hFFFF, 1, 2, 1, 9);
      cycle(0, 0, 0, 0, 9, 9, 0, 0);
      // Upper half of the 32-entry file.
      cycle(0, 1, 31, 32'hCAFEF00D, 31, 16, 0, 0);
      cycle(0, 1, 16, 32'h1, 31, 16, 0, 0);
      cycle(0, 0, 0, 0, 31, 16, 0, 0);

      // Randomised traffic with forced index collisions.
      for (int n = 0; n < 600; n++) begin
         w = 5'($urandom_range(0, 31));
         s = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
         a = ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31));
         b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
         d = $urandom;
         cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 1) == 1), w, d, a, b,
               ($urandom_range(0, 2) == 0), s);
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL drain: %0d responses left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RV32E/RV32I cores. It provides two asynchronous read ports (rs1/rs2), one synchronous write port, and synchronous reset of all storage. Register 0 can optionally be hardwired to zero, and same-cycle write-to-read bypass is optional. A per-register busy scoreboard lets the multi-cycle control FSM stall on registers with an outstanding write.

Parameters:
BIT_WIDTH, 32, data width of each register.
NUM_REGS, 16, register count; must be a power of two, 16 (RV32E) or 32 (RV32I).
ADDR_W, $clog2(NUM_REGS), register index width (localparam, not overridable).
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and never becomes busy.
BYPASS, 1, 1 = a read of the register being written this cycle returns data_in.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
data_in  input  BIT_WIDTH  write data.
write_en  input  1  write enable.
write_reg  input  ADDR_W  register to be written.
read_reg_a  input  ADDR_W  read port A index (rs1).
read_reg_b  input  ADDR_W  read port B index (rs2).
data_out_a  output  BIT_WIDTH  read port A data.
data_out_b  output  BIT_WIDTH  read port B data.
busy_set_en  input  1  mark a register as having a pending write.
busy_set_reg  input  ADDR_W  register to mark busy.
busy_a  output  1  busy bit of read_reg_a.
busy_b  output  1  busy bit of read_reg_b.
busy_any  output  1  OR of all busy bits.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- On a rising clk edge with rst=1, all NUM_REGS registers and all busy bits are cleared to 0. write_en and busy_set_en are ignored that cycle.
- Output values after reset: data_out_a/b = 0 for any index, busy_a/b = 0, busy_any = 0.
- Write: on a rising clk edge with rst=0 and write_en=1, x[write_reg] <= data_in. The new value is visible on read ports in the next cycle.
- Read: data_out_a/b are combinational from read_reg_a/b, with zero cycles of latency.
- Bypass (BYPASS=1): if write_en=1 and read_reg_x==write_reg, data_out_x = data_in in the same cycle.
- Bypass (BYPASS=0): if write_en=1 and read_reg_x==write_reg, data_out_x returns the old stored value.
- ZERO_REG=1:
  - Writes to register 0 are discarded.
  - data_out for index 0 is always 0, including under bypass.
  - busy_set for register 0 is ignored; busy for register 0 is constant 0.
- ZERO_REG=0: register 0 behaves like any other register.
- Both read ports may address the same register and must return identical data.
- Scoreboard, per register, on a rising clk edge with rst=0:
  - busy_set_en=1 sets busy[busy_set_reg].
  - write_en=1 clears busy[write_reg].
  - If both target the same register in the same cycle, set wins and busy ends at 1 (a new writer has been issued).
  - Set and clear on different registers both take effect.
- busy_a/b = busy[read_reg_a/b], combinational, with no bypass: a register written this cycle still reports busy until the edge.
- busy_any is combinational over the stored busy bits.
- A write to a non-busy register is legal and leaves busy at 0.
- Reset mid-operation: a write or busy_set coincident with rst=1 is lost. The register reads 0 afterwards.
- Index width is exactly ADDR_W, so every index is in range and there is no out-of-range case.

Test Plan:
1. Reset then read all indices on both ports -> every data_out = 0, busy_any = 0. Write x5=0xDEADBEEF, then read a=5, b=5 next cycle -> both 0xDEADBEEF.
2. With ZERO_REG=1, write x0=0x12345678 with read_reg_a=0 in the same and next cycles -> data_out_a = 0 both cycles. busy_set on reg 0 -> busy stays 0.
3. BYPASS=1: write x3=0xA5A5A5A5 with read_reg_b=3 in the same cycle -> data_out_b = 0xA5A5A5A5 that cycle. Repeat with BYPASS=0 and old x3=0x1 -> 0x1, then 0xA5A5A5A5 next cycle.
4. Scoreboard: busy_set x7 -> busy_a (a=7) = 1 next cycle and busy_any = 1. Write x7 -> busy_a = 0 next cycle. Simultaneous busy_set x7 and write x7 -> busy stays 1, data updated.
5. Assert rst in the same cycle as a write x9=0xFFFF and busy_set x9 -> next cycle x9 reads 0 and busy = 0.
6. NUM_REGS=32: write x31=0xCAFEF00D and x16=0x1, read a=31, b=16 -> 0xCAFEF00D and 0x1. Random write/read sequences match a golden array model.
